vc_mem_net_adapter: RTL and testbench

//  Memory-side network adapter; sits at each cache/memory bank, opposite end from the processor adapter.

---
 rtl/vc_mem_net_adapter_pkg.sv | 26 ++
 rtl/vc_mem_net_adapter_src_id_queue.sv | 66 ++++++
 rtl/vc_mem_net_adapter.sv | 99 +++++++++
 tb/tb_vc_mem_net_adapter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_mem_net_adapter_pkg.sv
// Shared sizing helpers for the memory-side network adapter.
// Message layouts: memreq {type,addr,len,data}, memresp {type,len,data}.
package vc_mem_net_adapter_pkg;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int len_sz(input int data_sz);
    return clog2_min1(data_sz / 8);
  endfunction

  function automatic int memreq_msg_sz(input int addr_sz, input int data_sz);
    return 1 + addr_sz + len_sz(data_sz) + data_sz;
  endfunction

  function automatic int memresp_msg_sz(input int data_sz);
    return 1 + len_sz(data_sz) + data_sz;
  endfunction

  // Network message: {dest, src, payload}, dest in the MSBs.
  function automatic int net_msg_sz(input int payload_sz, input int srcdest_sz);
    return 2 * srcdest_sz + payload_sz;
  endfunction

endpackage

// File: rtl/vc_mem_net_adapter_src_id_queue.sv
// In-order queue of request source ids, any depth >= 1.
// Pipe-mode enqueue: a full queue accepts when it dequeues the same cycle.
module vc_mem_net_adapter_src_id_queue
  import vc_mem_net_adapter_pkg::*;
#(
  parameter int p_depth = 4,
  parameter int p_width = 2,
  localparam int c_cnt_sz = $clog2(p_depth + 1),
  localparam int c_ptr_sz = clog2_min1(p_depth)
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                enq_val,
  output logic                enq_rdy,
  input  logic [p_width-1:0]  enq_bits,
  output logic                deq_val,
  input  logic                deq_rdy,
  output logic [p_width-1:0]  deq_bits,
  output logic [c_cnt_sz-1:0] count
);

  localparam logic [c_ptr_sz-1:0] c_last = c_ptr_sz'(p_depth - 1);
  localparam logic [c_cnt_sz-1:0] c_full = c_cnt_sz'(p_depth);

  logic [p_width-1:0]  mem [p_depth];
  logic [c_ptr_sz-1:0] wr_ptr;
  logic [c_ptr_sz-1:0] rd_ptr;
  logic                full;
  logic                empty;
  logic                enq_fire;
  logic                deq_fire;

  assign full     = (count == c_full);
  assign empty    = (count == '0);
  assign deq_val  = !empty;
  assign deq_fire = deq_val && deq_rdy;
  assign enq_rdy  = !full || deq_fire;
  assign enq_fire = enq_val && enq_rdy;
  assign deq_bits = mem[rd_ptr];

  // Pointers wrap by explicit compare so non-power-of-two depths work.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire)
        wr_ptr <= (wr_ptr == c_last) ? '0 : wr_ptr + 1'b1;
      if (deq_fire)
        rd_ptr <= (rd_ptr == c_last) ? '0 : rd_ptr + 1'b1;
      unique case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (enq_fire)
      mem[wr_ptr] <= enq_bits;
  end

endmodule

// File: rtl/vc_mem_net_adapter.sv
// Memory-side network adapter: strips request headers, re-wraps responses.
// Optional: VC_MEM_NET_ADAPTER_DEST_CHECK_EN drops misrouted requests, sets err_dest.
module vc_mem_net_adapter
  import vc_mem_net_adapter_pkg::*;
#(
  parameter int p_router_id    = 0,
  parameter int p_num_nodes    = 4,
  parameter int p_addr_sz      = 8,
  parameter int p_data_sz      = 32,
  parameter int p_max_inflight = 4,
  localparam int c_srcdest_sz     = $clog2(p_num_nodes),
  localparam int c_memreq_msg_sz  = memreq_msg_sz(p_addr_sz, p_data_sz),
  localparam int c_memresp_msg_sz = memresp_msg_sz(p_data_sz),
  localparam int c_reqnet_msg_sz  = net_msg_sz(c_memreq_msg_sz, c_srcdest_sz),
  localparam int c_respnet_msg_sz = net_msg_sz(c_memresp_msg_sz, c_srcdest_sz),
  localparam int c_cnt_sz         = $clog2(p_max_inflight + 1)
)(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [c_reqnet_msg_sz-1:0]  reqnet_msg,
  input  logic                        reqnet_val,
  output logic                        reqnet_rdy,
  output logic [c_memreq_msg_sz-1:0]  memreq_msg,
  output logic                        memreq_val,
  input  logic                        memreq_rdy,
  input  logic [c_memresp_msg_sz-1:0] memresp_msg,
  input  logic                        memresp_val,
  output logic                        memresp_rdy,
  output logic [c_respnet_msg_sz-1:0] respnet_msg,
  output logic                        respnet_val,
  input  logic                        respnet_rdy
`ifdef VC_MEM_NET_ADAPTER_DEST_CHECK_EN
  ,
  output logic                        err_dest
`endif
);

  localparam int c_w = c_reqnet_msg_sz;
  localparam logic [c_srcdest_sz-1:0] c_router_id = c_srcdest_sz'(p_router_id);

  logic [c_srcdest_sz-1:0] dest;
  logic [c_srcdest_sz-1:0] src;
  logic [c_srcdest_sz-1:0] head_src;
  logic [c_cnt_sz-1:0]     count;
  logic                    push_ok;
  logic                    enq_val;
  logic                    deq_val;
  logic                    deq_rdy;
  logic                    dest_bad;

  assign dest       = reqnet_msg[c_w-1 -: c_srcdest_sz];
  assign src        = reqnet_msg[c_w-c_srcdest_sz-1 -: c_srcdest_sz];
  assign memreq_msg = reqnet_msg[c_memreq_msg_sz-1:0];

`ifdef VC_MEM_NET_ADAPTER_DEST_CHECK_EN
  logic unused_count;
  assign unused_count = ^count;
  assign dest_bad     = (dest != c_router_id);

  // Sticky misroute flag; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_dest <= 1'b0;
    else if (reqnet_val && dest_bad)
      err_dest <= 1'b1;
  end
`else
  logic unused_bits;
  assign unused_bits = ^{dest, count};
  assign dest_bad    = 1'b0;
`endif

  // Misrouted messages are consumed without touching the bank or queue.
  assign reqnet_rdy = dest_bad || (memreq_rdy && push_ok);
  assign memreq_val = reqnet_val && push_ok && !dest_bad;
  assign enq_val    = reqnet_val && memreq_rdy && !dest_bad;

  // A response pops only when the network takes it; no bypass when empty.
  assign deq_rdy     = memresp_val && respnet_rdy;
  assign respnet_val = memresp_val && deq_val;
  assign memresp_rdy = respnet_rdy && deq_val;
  assign respnet_msg = {head_src, c_router_id, memresp_msg};

  vc_mem_net_adapter_src_id_queue #(
    .p_depth (p_max_inflight),
    .p_width (c_srcdest_sz)
  ) src_q (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (enq_val),
    .enq_rdy  (push_ok),
    .enq_bits (src),
    .deq_val  (deq_val),
    .deq_rdy  (deq_rdy),
    .deq_bits (head_src),
    .count    (count)
  );

endmodule

// File: tb/tb_vc_mem_net_adapter.sv
// Bench: lane 0 (router 0, depth 4) directed; lane 1 (router 2, depth 3) random.
// A queue-level model checks both lanes every cycle.
module tb_vc_mem_net_adapter;

  localparam int NQ = 47;
  localparam int MQ = 43;
  localparam int MR = 35;
  localparam int NR = 39;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic [NQ-1:0] reqnet_msg [2];
  logic          reqnet_val [2];
  logic          reqnet_rdy [2];
  logic [MQ-1:0] memreq_msg [2];
  logic          memreq_val [2];
  logic          memreq_rdy [2];
  logic [MR-1:0] memresp_msg [2];
  logic          memresp_val [2];
  logic          memresp_rdy [2];
  logic [NR-1:0] respnet_msg [2];
  logic          respnet_val [2];
  logic          respnet_rdy [2];
`ifdef VC_MEM_NET_ADAPTER_DEST_CHECK_EN
  logic          err_dest [2];
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : lane
    vc_mem_net_adapter #(
      .p_router_id    (g == 0 ? 0 : 2),
      .p_num_nodes    (4),
      .p_addr_sz      (8),
      .p_data_sz      (32),
      .p_max_inflight (g == 0 ? 4 : 3)
    ) dut (
      .clk         (clk),
      .reset       (reset),
      .reqnet_msg  (reqnet_msg[g]),
      .reqnet_val  (reqnet_val[g]),
      .reqnet_rdy  (reqnet_rdy[g]),
      .memreq_msg  (memreq_msg[g]),
      .memreq_val  (memreq_val[g]),
      .memreq_rdy  (memreq_rdy[g]),
      .memresp_msg (memresp_msg[g]),
      .memresp_val (memresp_val[g]),
      .memresp_rdy (memresp_rdy[g]),
      .respnet_msg (respnet_msg[g]),
      .respnet_val (respnet_val[g]),
      .respnet_rdy (respnet_rdy[g])
`ifdef VC_MEM_NET_ADAPTER_DEST_CHECK_EN
      ,
      .err_dest    (err_dest[g])
`endif
    );
  end

  function automatic int depth_of(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic logic [1:0] rid_of(input int k);
    return (k == 0) ? 2'd0 : 2'd2;
  endfunction

  task automatic chk(input string nm, input int k,
                     input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s lane%0d: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  // Reference model: per-lane list of src ids, oldest at index 0.
  logic [1:0] mq [2][0:7];
  int         msz [2];
  logic       merr [2];

  initial begin
    msz[0] = 0;
    msz[1] = 0;
    merr[0] = 1'b0;
    merr[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!reset) begin
          msz[k] = 0;
          merr[k] = 1'b0;
          chk("rst_respnet_val", k, 64'(respnet_val[k]), 64'(0));
          chk("rst_memresp_rdy", k, 64'(memresp_rdy[k]), 64'(0));
`ifdef VC_MEM_NET_ADAPTER_DEST_CHECK_EN
          chk("rst_err_dest", k, 64'(err_dest[k]), 64'(0));
`endif
        end else begin
          logic empty, full, bad, pop, pok, e_qrdy, e_mval;
          empty = (msz[k] == 0);
          full  = (msz[k] == depth_of(k));
          bad   = 1'b0;
`ifdef VC_MEM_NET_ADAPTER_DEST_CHECK_EN
          bad   = (reqnet_msg[k][46:45] != rid_of(k));
`endif
          pop    = memresp_val[k] && !empty && respnet_rdy[k];
          pok    = !full || pop;
          e_qrdy = bad ? 1'b1 : (memreq_rdy[k] && pok);
          e_mval = reqnet_val[k] && pok && !bad;
          chk("reqnet_rdy", k, 64'(reqnet_rdy[k]), 64'(e_qrdy));
          chk("memreq_val", k, 64'(memreq_val[k]), 64'(e_mval));
          chk("respnet_val", k, 64'(respnet_val[k]),
              64'(memresp_val[k] && !empty));
          chk("memresp_rdy", k, 64'(memresp_rdy[k]),
              64'(respnet_rdy[k] && !empty));
          if (e_mval)
            chk("memreq_msg", k, 64'(memreq_msg[k]),
                64'(reqnet_msg[k][MQ-1:0]));
          if (memresp_val[k] && !empty)
            chk("respnet_msg", k, 64'(respnet_msg[k]),
                64'({mq[k][0], rid_of(k), memresp_msg[k]}));
`ifdef VC_MEM_NET_ADAPTER_DEST_CHECK_EN
          chk("err_dest", k, 64'(err_dest[k]), 64'(merr[k]));
          if (reqnet_val[k] && bad)
            merr[k] = 1'b1;
`endif
          if (pop) begin
            for (int i = 0; i < 7; i++)
              mq[k][i] = mq[k][i+1];
            msz[k] = msz[k] - 1;
          end
          if (reqnet_val[k] && e_qrdy && !bad) begin
            mq[k][msz[k]] = reqnet_msg[k][44:43];
            msz[k] = msz[k] + 1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NQ-1:0] mk(input logic [1:0] d,
                                       input logic [1:0] s,
                                       input logic [MQ-1:0] p);
    return {d, s, p};
  endfunction

  logic [MQ-1:0] p1;
  logic [MR-1:0] r1;
  logic [MQ-1:0] cur;
  logic [MR-1:0] bq [$];
  logic [1:0]    srcs [4];
  int            sent;
  int            got;
  int            ncyc;
  logic          req_f;
  logic          resp_f;

  initial begin
    for (int k = 0; k < 2; k++) begin
      reqnet_msg[k]  = '0;
      reqnet_val[k]  = 1'b0;
      memreq_rdy[k]  = 1'b1;
      memresp_msg[k] = '0;
      memresp_val[k] = 1'b0;
      respnet_rdy[k] = 1'b1;
    end
    reqnet_msg[1] = mk(2'd2, 2'd0, '0);
    p1 = {1'b1, 8'h12, 2'd3, 32'hDEADBEEF};
    r1 = {1'b0, 2'd0, 32'hCAFEF00D};
    srcs[0] = 2'd1;
    srcs[1] = 2'd3;
    srcs[2] = 2'd0;
    srcs[3] = 2'd2;

    step();
    chk("rst_reqnet_rdy", 0, 64'(reqnet_rdy[0]), 64'(1));
    step();
    reset = 1'b1;
    step();

    // Single request, then its response.
    reqnet_msg[0] = mk(2'd0, 2'd2, p1);
    reqnet_val[0] = 1'b1;
    #1;
    chk("t1_memreq_msg", 0, 64'(memreq_msg[0]), 64'(p1));
    chk("t1_memreq_val", 0, 64'(memreq_val[0]), 64'(1));
    step();
    reqnet_val[0]  = 1'b0;
    memresp_msg[0] = r1;
    memresp_val[0] = 1'b1;
    #1;
    chk("t1_respnet_msg", 0, 64'(respnet_msg[0]),
        64'({2'd2, 2'd0, 35'h0CAFEF00D}));
    chk("t1_respnet_val", 0, 64'(respnet_val[0]), 64'(1));
    step();
    memresp_val[0] = 1'b0;

    // Fill to depth 4 with network stalled, then a 5th stalls.
    respnet_rdy[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      reqnet_msg[0] = mk(2'd0, srcs[i], MQ'(i + 16));
      reqnet_val[0] = 1'b1;
      step();
    end
    reqnet_msg[0] = mk(2'd0, 2'd1, MQ'(99));
    #1;
    chk("full_reqnet_rdy", 0, 64'(reqnet_rdy[0]), 64'(0));
    chk("full_memreq_val", 0, 64'(memreq_val[0]), 64'(0));

    // Full queue: push and pop in one cycle.
    memresp_val[0] = 1'b1;
    respnet_rdy[0] = 1'b1;
    #1;
    chk("pp_reqnet_rdy", 0, 64'(reqnet_rdy[0]), 64'(1));
    chk("pp_dest", 0, 64'(respnet_msg[0][38:37]), 64'(1));
    step();
    reqnet_val[0] = 1'b0;

    // Drain: order 3,0,2 then the pipelined 1.
    srcs[0] = 2'd3;
    srcs[1] = 2'd0;
    srcs[2] = 2'd2;
    srcs[3] = 2'd1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_dest", 0, 64'(respnet_msg[0][38:37]), 64'(srcs[i]));
      step();
    end

    // Empty: responses blocked, no bypass from a same-cycle push.
    #1;
    chk("empty_respnet_val", 0, 64'(respnet_val[0]), 64'(0));
    chk("empty_memresp_rdy", 0, 64'(memresp_rdy[0]), 64'(0));
    reqnet_msg[0] = mk(2'd0, 2'd3, p1);
    reqnet_val[0] = 1'b1;
    #1;
    chk("nobypass_respnet_val", 0, 64'(respnet_val[0]), 64'(0));
    step();
    reqnet_val[0] = 1'b0;
    #1;
    chk("after_push_dest", 0, 64'(respnet_msg[0][38:37]), 64'(3));
    step();
    memresp_val[0] = 1'b0;

`ifdef VC_MEM_NET_ADAPTER_DEST_CHECK_EN
    reqnet_msg[0] = mk(2'd1, 2'd0, p1);
    reqnet_val[0] = 1'b1;
    memreq_rdy[0] = 1'b0;
    #1;
    chk("dc_reqnet_rdy", 0, 64'(reqnet_rdy[0]), 64'(1));
    chk("dc_memreq_val", 0, 64'(memreq_val[0]), 64'(0));
    step();
    reqnet_val[0] = 1'b0;
    memreq_rdy[0] = 1'b1;
    #1;
    chk("dc_err_dest", 0, 64'(err_dest[0]), 64'(1));
    step();
`endif

    // Random stalls on lane 1 (depth 3), 200 messages, in-order bank.
    sent = 0;
    got  = 0;
    ncyc = 0;
    cur  = MQ'({$urandom, $urandom});
    while (got < 200 && ncyc < 6000) begin
      reqnet_val[1]  = (sent < 200);
      reqnet_msg[1]  = mk(2'd2, 2'($urandom_range(0, 3)), cur);
      memreq_rdy[1]  = ($urandom_range(0, 3) != 0);
      respnet_rdy[1] = ($urandom_range(0, 2) != 0);
      memresp_val[1] = (bq.size() != 0);
      memresp_msg[1] = (bq.size() != 0) ? bq[0] : '0;
      #1;
      req_f  = reqnet_val[1] && reqnet_rdy[1];
      resp_f = respnet_val[1] && respnet_rdy[1];
      step();
      if (resp_f) begin
        void'(bq.pop_front());
        got++;
      end
      if (req_f) begin
        bq.push_back({1'b0, 2'd0, cur[31:0]});
        sent++;
        cur = MQ'({$urandom, $urandom});
      end
      ncyc++;
    end
    chk("rand_responses", 1, 64'(got), 64'(200));
    reqnet_val[1]  = 1'b0;
    memresp_val[1] = 1'b0;
    step();

    // Async reset between edges with traffic queued.
    reqnet_msg[0] = mk(2'd0, 2'd1, p1);
    reqnet_val[0] = 1'b1;
    step();
    reqnet_msg[0] = mk(2'd0, 2'd2, p1);
    step();
    reqnet_val[0]  = 1'b0;
    memresp_val[0] = 1'b1;
    respnet_rdy[0] = 1'b1;
    #1;
    chk("pre_rst_respnet_val", 0, 64'(respnet_val[0]), 64'(1));
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst_respnet_val", 0, 64'(respnet_val[0]), 64'(0));
    chk("async_rst_memresp_rdy", 0, 64'(memresp_rdy[0]), 64'(0));
    step();
    reset = 1'b1;
    step();
    chk("post_rst_respnet_val", 0, 64'(respnet_val[0]), 64'(0));
    memresp_val[0] = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
